m31_addsub_pipe: RTL

Pipelined, multi-lane modular add/subtract unit over the Mersenne field p = 2^W − 1 (default W = 31, p = 0x7FFFFFFF). It replaces the combinational add-then-reduce path in the Monolith datapath wherever a registered, back-pressurable stage is needed, such as between round-constant injection and the S-box/MDS stages. Each accepted transaction carries LANES independent operand pairs, a shared add/sub mode and a pass-through tag. It produces canonical residues in [0, p−1] after a fixed two-cycle latency, at a throughput of one transaction per cycle.

---
 rtl/m31_pkg.sv | 15 +
 rtl/m31_addsub_pipe_if.sv | 32 +++
 rtl/m31_lane_reduce.sv | 21 ++
 rtl/m31_addsub_pipe.sv | 94 +++++++++
 4 files changed

// File: rtl/m31_pkg.sv
// Shared Mersenne-31 field definitions for the Monolith datapath.
// The pipeline and lane-reduce modules import this package.
package m31_pkg;

  localparam int unsigned M31_W = 31;
  localparam logic [30:0] M31_P = 31'h7FFFFFFF;

  typedef logic [M31_W-1:0] m31_t;

  // Modulus 2^w - 1 for an arbitrary Mersenne exponent (w < 64).
  function automatic logic [63:0] mersenne_modulus(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/m31_addsub_pipe_if.sv
// Transaction bundle for m31_addsub_pipe: input side (in_*) and result side (out_*).
// Handshake: a beat transfers on a rising edge where valid && ready; ready may
// depend on the partner's signals, valid never waits for ready.
interface m31_addsub_pipe_if #(
  parameter int W         = 31,
  parameter int LANES     = 16,
  parameter int TAG_WIDTH = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sub;
  logic [LANES*W-1:0]   in_a;
  logic [LANES*W-1:0]   in_b;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_res;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_sub, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );

endinterface

// File: rtl/m31_lane_reduce.sv
// Single-lane fold of a (W+1)-bit raw sum into a canonical residue mod 2^W - 1.
module m31_lane_reduce
  import m31_pkg::*;
#(
  parameter int W = M31_W
) (
  input  logic [W:0]   s,
  output logic [W-1:0] r
);

  localparam logic [W-1:0] P = W'(mersenne_modulus(W));

  logic [W-1:0] fold;

  // s <= 2p, so the end-around carry cannot overflow W bits.
  always_comb begin
    fold = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    r    = (fold == P) ? '0 : fold;
  end

endmodule

// File: rtl/m31_addsub_pipe.sv
// Two-stage, back-pressurable multi-lane add/sub over GF(2^W - 1).
// Optional build macro: M31_ADDSUB_STATS_EN adds the out_count transfer counter.
module m31_addsub_pipe
  import m31_pkg::*;
#(
  parameter int W         = M31_W,
  parameter int LANES     = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  m31_addsub_pipe_if.slave   bus
`ifdef M31_ADDSUB_STATS_EN
  ,
  output logic [31:0]        out_count
`endif
);

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_move;
  logic                 accept;
  logic [W:0]           s1_raw   [LANES];
  logic [W:0]           raw_next [LANES];
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [TAG_WIDTH-1:0] s2_tag;
  logic [LANES*W-1:0]   s2_res;
  logic [LANES*W-1:0]   reduced;

  // Stage 1 may advance whenever stage 2 is empty or being drained.
  assign s1_move       = !s2_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s1_move;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_res   = s2_res;
  assign bus.out_tag   = s2_tag;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0] a_l;
    logic [W-1:0] b_l;

    // For b in [0, p], ~b is p - b, so subtraction reuses the adder.
    assign a_l         = bus.in_a[l*W +: W];
    assign b_l         = bus.in_sub ? ~bus.in_b[l*W +: W] : bus.in_b[l*W +: W];
    assign raw_next[l] = {1'b0, a_l} + {1'b0, b_l};

    m31_lane_reduce #(.W(W)) u_reduce (
      .s (s1_raw[l]),
      .r (reduced[l*W +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      s2_res   <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_raw[l] <= '0;
      end
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_tag <= bus.in_tag;
        for (int l = 0; l < LANES; l++) begin
          s1_raw[l] <= raw_next[l];
        end
      end
      if (s1_move) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_res <= reduced;
          s2_tag <= s1_tag;
        end
      end
    end
  end

`ifdef M31_ADDSUB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (s2_valid && bus.out_ready) begin
      out_count <= out_count + 32'd1;
    end
  end
`endif

endmodule
